// File: rtl/tt_pad_pkg.sv
// tt_pad_pkg: shared definitions for the pad configuration controller.
//   - bit positions inside a pad config word {pu,pd,cs,sl,ie,oe}
//   - CFG_W / CFG_RESET: config width and the post-reset config (input enabled)
//   - state_t: controller states
//   - rsp_t: registered response bundle
package tt_pad_pkg;
   localparam int OE    = 0;
   localparam int IE    = 1;
   localparam int SL    = 2;
   localparam int CS    = 3;
   localparam int PD    = 4;
   localparam int PU    = 5;
   localparam int CFG_W = 6;

   localparam logic [CFG_W-1:0] CFG_RESET = 6'b000010;

   typedef enum logic {IDLE, DRAIN} state_t;

   typedef struct packed {
      logic             valid;
      logic             err;
      logic [CFG_W:0]   rdata;   // {y_sync, cfg}
   } rsp_t;
endpackage

// File: rtl/tt_pad_sync.sv
// tt_pad_sync: STAGES-deep single-bit synchroniser.
//   clk, rst_n : block clock, synchronous active-low reset
//   d          : asynchronous input
//   q          : d after STAGES clock edges
module tt_pad_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];
endmodule

// File: rtl/tt_pad_cfg_ctrl.sv
// tt_pad_cfg_ctrl: per-pad control register file for GF pad cells.
//   clk, rst_n            : block clock, synchronous active-low reset
//   cmd_*                 : valid/ready command port (read / write one pad config)
//   rsp_*                 : one-cycle response per accepted command
//   core_out / core_in    : core data to pads / synchronised pad Y back to core
//   pad_y                 : raw pad Y inputs
//   pad_a..pad_pu         : registered pad cell controls
// Config changes that involve an enabled output are applied break-before-make:
// OE is dropped first, held low for GUARD_CYCLES, then the new config lands.
import tt_pad_pkg::*;

module tt_pad_cfg_ctrl #(
   parameter int NUM_PADS     = 8,
   parameter int ADDR_W       = 3,
   parameter int GUARD_CYCLES = 2,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [CFG_W-1:0]    cmd_wdata,
   output logic                rsp_valid,
   output logic                rsp_err,
   output logic [CFG_W:0]      rsp_rdata,
   input  logic [NUM_PADS-1:0] core_out,
   output logic [NUM_PADS-1:0] core_in,
   input  logic [NUM_PADS-1:0] pad_y,
   output logic [NUM_PADS-1:0] pad_a,
   output logic [NUM_PADS-1:0] pad_oe,
   output logic [NUM_PADS-1:0] pad_ie,
   output logic [NUM_PADS-1:0] pad_sl,
   output logic [NUM_PADS-1:0] pad_cs,
   output logic [NUM_PADS-1:0] pad_pd,
   output logic [NUM_PADS-1:0] pad_pu
);
   localparam logic [ADDR_W:0] PADS_LIM  = (ADDR_W+1)'(NUM_PADS);
   localparam logic [3:0]      GUARD_LD  = 4'(GUARD_CYCLES - 1);

   logic [NUM_PADS-1:0][CFG_W-1:0] cfg;

   state_t              state, state_nxt;
   logic [3:0]          cnt, cnt_nxt;
   logic [ADDR_W-1:0]   lat_addr;
   logic [CFG_W-1:0]    lat_data;
   logic                lat_y;
   rsp_t                rsp, rsp_nxt;

   logic                in_range;
   logic [CFG_W-1:0]    cur_cfg;
   logic                cur_y;
   logic                cap;
   logic                oe_clr;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [CFG_W-1:0]    wr_data;

   assign in_range  = {1'b0, cmd_addr} < PADS_LIM;
   assign cur_cfg   = cfg[cmd_addr];
   assign cur_y     = core_in[cmd_addr];
   assign cmd_ready = (state == IDLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cap       = 1'b0;
      oe_clr    = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = lat_addr;
      wr_data   = lat_data;
      rsp_nxt   = '0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               rsp_nxt.valid = 1'b1;
               if (!in_range) begin
                  rsp_nxt.err = 1'b1;
               end else if (!cmd_write || cmd_wdata == cur_cfg) begin
                  rsp_nxt.rdata = {cur_y, cur_cfg};
               end else if (!cur_cfg[OE] && !cmd_wdata[OE]) begin
                  // output stays off on both sides: nothing to break first
                  wr_en         = 1'b1;
                  wr_addr       = cmd_addr;
                  wr_data       = cmd_wdata;
                  rsp_nxt.rdata = {cur_y, cmd_wdata};
               end else begin
                  // break: drop OE now, make once the guard expires
                  rsp_nxt   = '0;
                  oe_clr    = 1'b1;
                  cap       = 1'b1;
                  cnt_nxt   = GUARD_LD;
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               wr_en         = 1'b1;
               rsp_nxt.valid = 1'b1;
               rsp_nxt.rdata = {lat_y, lat_data};
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         lat_addr <= '0;
         lat_data <= '0;
         lat_y    <= 1'b0;
         rsp      <= '0;
         pad_a    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rsp   <= rsp_nxt;
         pad_a <= core_out;
         if (cap) begin
            lat_addr <= cmd_addr;
            lat_data <= cmd_wdata;
            lat_y    <= cur_y;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PADS; i++) begin
         if (!rst_n)                                       cfg[i]     <= CFG_RESET;
         else if (wr_en && wr_addr == ADDR_W'(i))          cfg[i]     <= wr_data;
         else if (oe_clr && cmd_addr == ADDR_W'(i))        cfg[i][OE] <= 1'b0;
      end
   end

   assign rsp_valid = rsp.valid;
   assign rsp_err   = rsp.err;
   assign rsp_rdata = rsp.rdata;

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
      assign pad_oe[i] = cfg[i][OE];
      assign pad_ie[i] = cfg[i][IE];
      assign pad_sl[i] = cfg[i][SL];
      assign pad_cs[i] = cfg[i][CS];
      assign pad_pd[i] = cfg[i][PD];
      assign pad_pu[i] = cfg[i][PU];

      tt_pad_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (pad_y[i]),
         .q     (core_in[i])
      );
   end
endmodule

// File: tb/tb_tt_pad_cfg_ctrl.sv
module tb_tt_pad_cfg_ctrl;
   localparam int NP = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [2:0]    cmd_addr;
   logic [5:0]    cmd_wdata;
   logic          rsp_valid, rsp_err;
   logic [6:0]    rsp_rdata;
   logic [NP-1:0] core_out, core_in, pad_y;
   logic [NP-1:0] pad_a, pad_oe, pad_ie, pad_sl, pad_cs, pad_pd, pad_pu;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   tt_pad_cfg_ctrl #(.NUM_PADS(NP), .ADDR_W(3), .GUARD_CYCLES(2), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .core_out(core_out), .core_in(core_in), .pad_y(pad_y),
      .pad_a(pad_a), .pad_oe(pad_oe), .pad_ie(pad_ie), .pad_sl(pad_sl),
      .pad_cs(pad_cs), .pad_pd(pad_pd), .pad_pu(pad_pu)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Issue one command; returns 1 ns after the accepting edge.
   task automatic send(input logic wr, input logic [2:0] a, input logic [5:0] d,
                       input logic exp_err, input logic [6:0] exp_rd, input logic expect_rsp);
      int n;
      if (expect_rsp) exp_q.push_back({exp_err, exp_rd});
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=ready_low required=ready_high");
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   // Monitor: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected actual=%0h required=none", {rsp_err, rsp_rdata});
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("rsp", {24'd0, rsp_err, rsp_rdata}, {24'd0, e});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      core_out = '0; pad_y = '0;
      step; step;
      chk("rst_oe",      pad_oe,    6'h00);
      chk("rst_ie",      pad_ie,    6'h3f);
      chk("rst_other",   {pad_sl, pad_cs, pad_pd, pad_pu}, 24'h0);
      chk("rst_core_in", core_in,   6'h00);
      chk("rst_pad_a",   pad_a,     6'h00);
      chk("rst_rsp",     rsp_valid, 1'b0);
      rst_n = 1'b1;
      step;
      chk("rst_ready",   cmd_ready, 1'b1);

      // pad_a follows core_out one edge later
      core_out = 6'b101101;
      step;
      chk("pad_a", pad_a, 6'b101101);

      // pad 3: oe 0->1, break-before-make
      send(1'b1, 3'd3, 6'b000011, 1'b0, 7'b0000011, 1'b1);
      chk("p3_oe_t0",    pad_oe[3], 1'b0);
      chk("p3_rdy_t0",   cmd_ready, 1'b0);
      step;
      chk("p3_oe_t1",    pad_oe[3], 1'b0);
      chk("p3_rdy_t1",   cmd_ready, 1'b0);
      step;
      chk("p3_oe_t2",    pad_oe[3], 1'b1);
      chk("p3_rdy_t2",   cmd_ready, 1'b1);

      // pad 3: output -> input with pull-down
      send(1'b1, 3'd3, 6'b010010, 1'b0, 7'b0010010, 1'b1);
      chk("p3b_oe_t0",   pad_oe[3], 1'b0);
      chk("p3b_pd_t0",   pad_pd[3], 1'b0);
      step;
      chk("p3b_pd_t1",   pad_pd[3], 1'b0);
      step;
      chk("p3b_pd_t2",   pad_pd,    6'b001000);
      chk("p3b_ie_t2",   pad_ie,    6'h3f);
      chk("p3b_oe_t2",   pad_oe,    6'h00);

      // pad 5: oe stays 0, applied at acceptance
      send(1'b1, 3'd5, 6'b000110, 1'b0, 7'b0000110, 1'b1);
      chk("p5_sl",       pad_sl,    6'b100000);
      chk("p5_rdy",      cmd_ready, 1'b1);
      send(1'b1, 3'd5, 6'b000110, 1'b0, 7'b0000110, 1'b1);
      chk("p5_same_sl",  pad_sl,    6'b100000);
      chk("p5_same_rdy", cmd_ready, 1'b1);

      // out-of-range address
      send(1'b1, 3'd7, 6'b111111, 1'b1, 7'b0000000, 1'b1);
      step;
      chk("err_outs", {pad_oe, pad_ie, pad_sl, pad_cs, pad_pd, pad_pu},
                      {6'h00, 6'h3f, 6'b100000, 6'h00, 6'b001000, 6'h00});

      // pad_y sync and read-back of y bit
      pad_y = 6'b000001;
      step; step; step;
      chk("core_in", core_in, 6'b000001);
      send(1'b0, 3'd0, 6'b000000, 1'b0, 7'b1000010, 1'b1);

      // reset during DRAIN: pending write dropped, no response
      send(1'b1, 3'd1, 6'b000001, 1'b0, 7'b0000000, 1'b0);
      rst_n = 1'b0;
      step;
      chk("rd_rsp",     rsp_valid, 1'b0);
      chk("rd_ready",   cmd_ready, 1'b1);
      chk("rd_oe",      pad_oe,    6'h00);
      chk("rd_ie",      pad_ie,    6'h3f);
      chk("rd_pd_sl",   {pad_pd, pad_sl}, 12'h0);
      chk("rd_core_in", core_in,   6'h00);
      rst_n = 1'b1;
      step; step; step;
      chk("rd_oe_late", pad_oe,    6'h00);
      send(1'b0, 3'd1, 6'b000000, 1'b0, 7'b0000010, 1'b1);
      send(1'b0, 3'd0, 6'b000000, 1'b0, 7'b1000010, 1'b1);

      step; step; step;
      chk("rsp_q_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
